// File: rtl/ff_pipe_pkg.sv
// ff_pipe_pkg
//   Shared constants and helpers for the ff_pipe_sync_rst register pipeline.
//   - MIN_W / MIN_DEPTH : smallest legal data width and stage count,
//                         checked at elaboration by the top.
//   - occ_w(depth)      : width of an occupancy count able to hold 0..depth.
package ff_pipe_pkg;

  localparam int MIN_W     = 1;
  localparam int MIN_DEPTH = 1;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ff_pipe_stage.sv
// ff_pipe_stage
//   One pipeline slot: a valid flag plus a W-bit data register.
//   Ports:
//     clk    in   clock, updates on posedge
//     rst    in   synchronous active-high reset: v <= 0, d <= RESET_VAL
//     load   in   capture d_in and mark the slot valid (wins over clear)
//     clear  in   mark the slot invalid; data is held
//     d_in   in   W-bit payload to capture on load
//     v_q    out  registered valid flag
//     d_q    out  registered payload
//   The data register only changes on load or rst, so an idle or
//   invalid slot never toggles.
module ff_pipe_stage #(
  parameter int             W         = 32,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d_in,
  output logic         v_q,
  output logic [W-1:0] d_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= RESET_VAL;
    end else if (load) begin
      v_q <= 1'b1;
      d_q <= d_in;
    end else if (clear) begin
      v_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ff_pipe_sync_rst.sv
// ff_pipe_sync_rst
//   DEPTH-stage W-bit register pipeline with valid/ready flow control,
//   bubble collapse, synchronous reset and flush.
//   Parameters: W (data width), DEPTH (stages), RESET_VAL (data reset value).
//   Ports:
//     clk        in   clock, all state updates on posedge
//     rst        in   synchronous reset, active-high, overrides flush
//     flush      in   synchronous discard of all contents (data held)
//     in_valid   in   producer has data on in_data
//     in_ready   out  pipeline accepts in_data this cycle
//     in_data    in   W-bit input payload
//     out_valid  out  last stage holds valid data (registered)
//     out_ready  in   consumer takes out_data this cycle
//     out_data   out  last-stage payload (registered)
//     occ        out  valid-stage count, present only when FF_PIPE_OCC_EN
//                     is defined
//   Handshake: a beat moves across an interface on a rising edge where
//   valid and ready are both high. valid never depends on ready; ready may
//   depend combinationally on downstream ready (the in_ready path ripples
//   through every stage so a full pipe can shift and accept in one cycle).
module ff_pipe_sync_rst
  import ff_pipe_pkg::*;
#(
  parameter int           W         = 32,
  parameter int           DEPTH     = 2,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
`ifdef FF_PIPE_OCC_EN
  ,
  output logic [occ_w(DEPTH)-1:0] occ
`endif
);

  generate
    if (W < MIN_W) begin : g_bad_w
      $error("ff_pipe_sync_rst: W must be >= %0d", MIN_W);
    end
    if (DEPTH < MIN_DEPTH) begin : g_bad_depth
      $error("ff_pipe_sync_rst: DEPTH must be >= %0d", MIN_DEPTH);
    end
  endgenerate

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] go;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] clear;
  logic [W-1:0]     d   [DEPTH];
  logic [W-1:0]     din [DEPTH];
  logic             accept;

  // Advance chain, walked from the output side back to the input side.
  // A stage may move forward when the next stage is empty (bubble
  // collapse) or is itself moving forward this cycle.
  always_comb begin
    go  = '0;
    adv = '0;
    go[DEPTH-1]  = out_ready;
    adv[DEPTH-1] = v[DEPTH-1] & out_ready;
    for (int s = DEPTH - 2; s >= 0; s--) begin
      go[s]  = !v[s+1] | adv[s+1];
      adv[s] = v[s] & go[s];
    end
  end

  assign in_ready = !rst & !flush & (!v[0] | adv[0]);
  assign accept   = in_valid & in_ready;

  // A stage that forwards its beat is vacated (clear); load has priority
  // inside the stage so a vacated-and-refilled stage stays valid. Flush
  // suppresses every load and clears every stage without touching data.
  always_comb begin
    load    = '0;
    load[0] = accept;
    for (int s = 1; s < DEPTH; s++) begin
      load[s] = !flush & adv[s-1];
    end
    clear = {DEPTH{flush}} | adv;
  end

  assign din[0] = in_data;

  genvar gs;
  generate
    for (gs = 0; gs < DEPTH; gs++) begin : g_stage
      if (gs > 0) begin : g_link
        assign din[gs] = d[gs-1];
      end
      ff_pipe_stage #(
        .W         (W),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk   (clk),
        .rst   (rst),
        .load  (load[gs]),
        .clear (clear[gs]),
        .d_in  (din[gs]),
        .v_q   (v[gs]),
        .d_q   (d[gs])
      );
    end
  endgenerate

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

`ifdef FF_PIPE_OCC_EN
  localparam int OW = occ_w(DEPTH);

  logic [OW-1:0] occ_q;
  logic [OW-1:0] pop_cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OW'(accept) - OW'(out_valid & out_ready);
    end
  end

  always_comb begin
    pop_cnt = '0;
    for (int s = 0; s < DEPTH; s++) begin
      pop_cnt = pop_cnt + OW'(v[s]);
    end
  end

  // The running counter must always agree with the valid flags.
  occ_matches_valid : assert property (@(posedge clk) disable iff (rst)
    occ_q == pop_cnt);

  assign occ = occ_q;
`endif

endmodule
